// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode PIO: CPU-written keycodes queued in a FIFO, drained via valid/ready.
// Optional interrupt logic and mask register enabled by defining KEYCODE_FIFO_IRQ_EN.
module keycode_fifo_pio #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] held_port,
   output logic              irq
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] held_q, held_d;

   logic wr_en, push_req, push, pop, flush, ovf_clr, ovf_set;
   logic empty, full;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   assign wr_en    = chipselect & ~write_n;
   assign push_req = wr_en && (address == 2'd0);
   assign push     = push_req & ~full;
   assign ovf_set  = push_req & full;
   assign flush    = wr_en && (address == 2'd1) && writedata[1];
   assign ovf_clr  = wr_en && (address == 2'd1) && writedata[0];
   assign pop      = ~empty & out_ready;

   assign out_valid = ~empty;
   assign out_port  = empty ? '0 : mem_q[rd_ptr_q];
   assign held_port = held_q;

   // Every writedata bit is consumed somewhere only in some parameterisations.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      held_d     = held_q;

      if (pop) held_d = out_port;

      // Flush overrides any same-cycle pop; held_port still captures the head.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      if (ovf_clr) overflow_d = 1'b0;
      if (ovf_set) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         held_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         held_q     <= held_d;
      end
   end

   // Storage needs no reset: out_port is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
   end

`ifdef KEYCODE_FIFO_IRQ_EN
   logic [1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (wr_en && (address == 2'd2)) mask_d = writedata[1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mask_q <= '0;
      else          mask_q <= mask_d;
   end

   assign irq = (mask_q[0] & overflow_q) | (mask_q[1] & empty);
`else
   logic [1:0] mask_q;
   assign mask_q = '0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      unique case (address)
         2'd0: readdata = 32'(out_port);
         2'd1: begin
            readdata[0]          = empty;
            readdata[1]          = full;
            readdata[2]          = overflow_q;
            readdata[8 +: CNT_W] = count_q;
         end
         2'd2: readdata = {30'd0, mask_q};
         2'd3: readdata = 32'(held_q);
         default: readdata = '0;
      endcase
   end

endmodule
